// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with a shared hex decoder.
// Optional build macro: LEADING_ZERO_BLANK_EN (dark slots for leading zero digits).

module hex2seven_seg (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);
  // Common-anode segments, active-low, bit order {g,f,e,d,c,b,a}.
  always_comb begin
    seg_o = 7'h7f;
    case (hex_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'ha: seg_o = 7'b0001000;
      4'hb: seg_o = 7'b0000011;
      4'hc: seg_o = 7'b1000110;
      4'hd: seg_o = 7'b0100001;
      4'he: seg_o = 7'b0000110;
      4'hf: seg_o = 7'b0001110;
      default: seg_o = 7'h7f;
    endcase
  end
endmodule

module seg_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_mask,
  output logic [6:0]            seven_segmnet,
  output logic                  dp,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_tick
);
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW   = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0]   BLANK_LAST = PW'(BLANK_CYCLES - 1);
  localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(DIGITS - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t                state_q, state_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic                  run_q, run_d;
  logic [4*DIGITS-1:0]   snap_val_q, snap_val_d;
  logic [DIGITS-1:0]     snap_dp_q, snap_dp_d;
  logic [3:0]            nib_q, nib_d;
  logic [DIGITS-1:0]     digit_sel_q, digit_sel_d;
  logic                  dp_q, dp_d;
  logic                  frame_tick_q, frame_tick_d;
  logic                  slot_end, show_d, lit_d;

  function automatic logic [3:0] pick_nib(input logic [4*DIGITS-1:0] v,
                                          input logic [IDXW-1:0] i);
    pick_nib = 4'h0;
    for (int k = 0; k < DIGITS; k++)
      if (i == IDXW'(k)) pick_nib = v[4*k +: 4];
  endfunction

  function automatic logic pick_bit(input logic [DIGITS-1:0] v,
                                    input logic [IDXW-1:0] i);
    pick_bit = 1'b0;
    for (int k = 0; k < DIGITS; k++)
      if (i == IDXW'(k)) pick_bit = v[k];
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  logic [IDXW-1:0] hi_q, hi_d;

  function automatic logic [IDXW-1:0] hi_digit(input logic [4*DIGITS-1:0] v);
    hi_digit = '0;
    for (int k = 0; k < DIGITS; k++)
      if (v[4*k +: 4] != 4'h0) hi_digit = IDXW'(k);
  endfunction
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    presc_d    = presc_q;
    run_d      = run_q;
    snap_val_d = snap_val_q;
    snap_dp_d  = snap_dp_q;
    nib_d      = nib_q;
`ifdef LEADING_ZERO_BLANK_EN
    hi_d       = hi_q;
`endif
    slot_end   = (presc_q == PRESC_LAST);

    if (!enable) begin
      run_d   = 1'b0;
      state_d = BLANK;
      idx_d   = '0;
      presc_d = '0;
    end else if (!run_q || (slot_end && idx_q == IDX_LAST)) begin
      // Frame start: snapshot inputs so a frame never mixes old and new digits.
      run_d      = 1'b1;
      state_d    = BLANK;
      idx_d      = '0;
      presc_d    = '0;
      snap_val_d = value;
      snap_dp_d  = dp_mask;
      nib_d      = value[3:0];
`ifdef LEADING_ZERO_BLANK_EN
      hi_d       = hi_digit(value);
`endif
    end else if (slot_end) begin
      state_d = BLANK;
      idx_d   = idx_q + 1'b1;
      presc_d = '0;
      nib_d   = pick_nib(snap_val_q, idx_d);
    end else begin
      presc_d = presc_q + 1'b1;
      if (state_q == BLANK && presc_q == BLANK_LAST) state_d = SHOW;
    end

    // Outputs are registered from next-state values so they align with state.
    show_d = run_d && (state_d == SHOW);
    lit_d  = show_d;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx_d > hi_d && !pick_bit(snap_dp_d, idx_d)) lit_d = 1'b0;
`endif
    for (int k = 0; k < DIGITS; k++)
      digit_sel_d[k] = !(lit_d && idx_d == IDXW'(k));
    dp_d         = show_d && pick_bit(snap_dp_d, idx_d);
    frame_tick_d = show_d && (presc_d == PRESC_LAST) && (idx_d == IDX_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= BLANK;
      idx_q        <= '0;
      presc_q      <= '0;
      run_q        <= 1'b0;
      snap_val_q   <= '0;
      snap_dp_q    <= '0;
      nib_q        <= 4'h0;
      digit_sel_q  <= '1;
      dp_q         <= 1'b0;
      frame_tick_q <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      hi_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      presc_q      <= presc_d;
      run_q        <= run_d;
      snap_val_q   <= snap_val_d;
      snap_dp_q    <= snap_dp_d;
      nib_q        <= nib_d;
      digit_sel_q  <= digit_sel_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
`ifdef LEADING_ZERO_BLANK_EN
      hi_q         <= hi_d;
`endif
    end
  end

  hex2seven_seg u_dec (
    .hex_i (nib_q),
    .seg_o (seven_segmnet)
  );

  assign digit_sel  = digit_sel_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;
endmodule
